uart_rx_engine: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fifo.sv | 47 ++++
 rtl/uart_rx_engine.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_engine.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and a width helper.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

    localparam int UART_DATA_BITS = 8;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic synchronous first-word-fall-through FIFO; head is visible on dout while not empty.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2_min1(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_engine.sv
// Oversampling 8N1 UART receiver with majority-voted bit sampling, sticky error flags
// and an FWFT receive FIFO.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 12_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    input  logic       rx_read,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = clog2_min1(DIV);
    localparam int SW      = clog2_min1(OVERSAMPLE);
    localparam int BW      = clog2_min1(UART_DATA_BITS);
    localparam int M       = OVERSAMPLE / 2;

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_LO      = SW'(M - 1);
    localparam logic [SW-1:0] S_MID     = SW'(M);
    localparam logic [SW-1:0] S_HI      = SW'(M + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_BITS - 1);

    rx_state_t                  state;
    logic                       rx_sync_p0;
    logic                       rx_sync_p1;
    logic                       rxs;
    logic [TW-1:0]              tick_cnt;
    logic                       tick;
    logic                       tick_run;
    logic [SW-1:0]              scnt;
    logic [BW-1:0]              bcnt;
    logic                       samp_lo;
    logic                       samp_mid;
    logic                       vote;
    logic                       decide;
    logic [UART_DATA_BITS-1:0]  shreg;
    logic                       good_byte;
    logic                       bad_stop;
    logic                       pop;
    logic                       fifo_full;
    logic                       fifo_empty;

    assign rxs       = rx_sync_p1;
    assign tick      = (tick_cnt == TICK_LAST);
    assign tick_run  = tick && (state != IDLE);
    assign decide    = tick_run && (scnt == S_HI);
    assign vote      = (samp_lo & samp_mid) | (samp_lo & rxs) | (samp_mid & rxs);
    assign good_byte = (state == STOP) && decide && vote;
    assign bad_stop  = (state == STOP) && decide && !vote;
    assign pop       = rx_read && rx_valid;
    assign rx_valid  = !fifo_empty;

    // Stage p0/p1: two-flop synchroniser for the asynchronous line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= uart_rx;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if ((state == IDLE && !rxs) || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
            scnt    <= '0;
            bcnt    <= '0;
        end else begin
            if (tick_run) scnt <= (scnt == S_LAST) ? '0 : scnt + 1'b1;
            case (state)
                IDLE: if (!rxs) begin
                    state   <= START;
                    rx_busy <= 1'b1;
                    scnt    <= '0;
                    bcnt    <= '0;
                end
                START: if (decide) begin
                    if (vote) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end else begin
                        state   <= DATA;
                    end
                end
                DATA: if (decide) begin
                    bcnt <= bcnt + 1'b1;
                    if (bcnt == BIT_LAST) state <= STOP;
                end
                STOP: if (decide) begin
                    if (vote) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end else begin
                        state   <= BREAK;
                    end
                end
                BREAK: if (rxs) begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

    // Vote samples and shift register carry no reset; the FSM never consumes them stale.
    always_ff @(posedge clk) begin
        if (tick_run && scnt == S_LO)  samp_lo  <= rxs;
        if (tick_run && scnt == S_MID) samp_mid <= rxs;
        if (state == DATA && decide)   shreg    <= {vote, shreg[UART_DATA_BITS-1:1]};
    end

    // A new error event takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (bad_stop)     frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
            if (good_byte && fifo_full && !pop) overrun <= 1'b1;
            else if (err_clr)                   overrun <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (good_byte),
        .pop   (pop),
        .din   (shreg),
        .dout  (rx_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx_engine.sv
// Scoreboard bench for uart_rx_engine at 16 clocks per bit (DIV=1).
module tb_uart_rx_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic       rx_read;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    int         ferr_rises = 0;
    logic       ferr_d = 1'b0;

    always #5 clk = ~clk;

    uart_rx_engine #(
        .CLK_HZ     (1_843_200),
        .BAUD       (115_200),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .rx_read   (rx_read),
        .err_clr   (err_clr),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always @(posedge clk) begin
        ferr_d <= frame_err;
        if (frame_err && !ferr_d) ferr_rises <= ferr_rises + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit, input bit check_busy);
        uart_rx = 1'b0;
        if (check_busy) begin
            repeat (3) @(negedge clk);
            chk("busy_rise", rx_busy, 1);
            repeat (13) @(negedge clk);
        end else begin
            repeat (16) @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (16) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (16) @(negedge clk);
    endtask

    task automatic gap(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic read_one(input string tag, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (rx_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk({tag, "_valid_timeout"}, rx_valid, 1);
        end else if (exp_q.size() == 0) begin
            chk({tag, "_spurious"}, rx_valid, 0);
        end else begin
            chk(tag, rx_data, exp_q.pop_front());
            rx_read = 1'b1;
            @(negedge clk);
            rx_read = 1'b0;
        end
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int base;
        rst     = 1'b0;
        uart_rx = 1'b1;
        rx_read = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", rx_valid, 0);
        chk("rst_busy", rx_busy, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_data", rx_data, 0);
        rst = 1'b1;
        gap(4);

        // Single byte: busy latency, data latency, pop.
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1, 1'b1);
        read_one("t1_data", 4);
        chk("t1_valid_after_read", rx_valid, 0);
        chk("t1_ferr", frame_err, 0);
        gap(4);

        // Short start-bit glitch is rejected silently.
        uart_rx = 1'b0;
        repeat (6) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("t2_busy_mid", rx_busy, 1);
        repeat (30) @(negedge clk);
        chk("t2_busy", rx_busy, 0);
        chk("t2_valid", rx_valid, 0);
        chk("t2_ferr", frame_err, 0);

        // Low stop bit followed by a held-low line.
        base = ferr_rises;
        send_byte(8'h3C, 1'b0, 1'b0);
        repeat (64) @(negedge clk);
        chk("t3_ferr", frame_err, 1);
        chk("t3_busy_break", rx_busy, 1);
        chk("t3_valid", rx_valid, 0);
        gap(6);
        chk("t3_busy_release", rx_busy, 0);
        chk("t3_ferr_once", ferr_rises - base, 1);
        pulse_err_clr();
        chk("t3_ferr_clr", frame_err, 0);

        // Five bytes into a four-deep FIFO with no reads.
        for (int d = 1; d <= 5; d++) begin
            if (d <= 4) exp_q.push_back(8'(d));
            send_byte(8'(d), 1'b1, 1'b0);
            gap(4);
            if (d == 4) chk("t4_no_ovr_yet", overrun, 0);
        end
        chk("t4_ovr", overrun, 1);
        for (int k = 0; k < 4; k++) read_one("t4_data", 4);
        chk("t4_empty", rx_valid, 0);
        pulse_err_clr();
        chk("t4_ovr_clr", overrun, 0);

        // Full FIFO, pop coincides with the fifth stop-bit decision.
        for (int d = 8'h11; d <= 8'h14; d++) begin
            exp_q.push_back(8'(d));
            send_byte(8'(d), 1'b1, 1'b0);
            gap(4);
        end
        exp_q.push_back(8'h15);
        fork
            send_byte(8'h15, 1'b1, 1'b0);
            begin
                repeat (156) @(negedge clk);
                chk("t5_head", rx_data, exp_q.pop_front());
                rx_read = 1'b1;
                @(negedge clk);
                rx_read = 1'b0;
            end
        join
        gap(4);
        chk("t5_no_ovr", overrun, 0);
        for (int k = 0; k < 4; k++) read_one("t5_data", 4);
        chk("t5_empty", rx_valid, 0);

        // Reset in the middle of a frame abandons it.
        fork
            send_byte(8'hFF, 1'b1, 1'b0);
            begin
                repeat (60) @(negedge clk);
                rst = 1'b0;
                repeat (3) @(negedge clk);
                chk("t6_rst_busy", rx_busy, 0);
                chk("t6_rst_data", rx_data, 0);
                rst = 1'b1;
            end
        join
        gap(8);
        chk("t6_no_ff", rx_valid, 0);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1, 1'b0);
        read_one("t6_data", 4);
        chk("t6_ferr", frame_err, 0);
        chk("t6_ovr", overrun, 0);
        chk("t6_empty", rx_valid, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
